dual_branch_predictor: RTL and testbench

Two-slot bimodal branch predictor for the dual-issue pipeline. It supplies the per-slot prediction bits that travel down to Execute and are compared against the resolved outcome by the hazard/flush logic. It sits at the fetch end of that loop. In Fetch it reads a table of 2-bit saturating counters for both fetch PCs. In Execute it receives resolved outcomes and mispredict signals back and trains the table. It also keeps branch and mispredict statistics counters.

---
 rtl/dual_branch_predictor.sv | 84 ++++++++
 tb/tb_dual_branch_predictor.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dual_branch_predictor.sv
// Two-slot bimodal branch predictor: 2-bit saturating counters indexed by
// word PC, read combinationally in Fetch, trained from Execute outcomes,
// plus branch/mispredict statistics counters.
module dual_branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  pcF1,
  input  logic [PC_WIDTH-1:0]  pcF2,
  output logic                 predictionF1,
  output logic                 predictionF2,
  input  logic                 enE,
  input  logic [PC_WIDTH-1:0]  pcE1,
  input  logic [PC_WIDTH-1:0]  pcE2,
  input  logic                 branchE1,
  input  logic                 branchE2,
  input  logic                 takenBranch1,
  input  logic                 takenBranch2,
  input  logic                 CPCSignal1,
  input  logic                 CPCSignal2,
  output logic [CNT_WIDTH-1:0] branchCount,
  output logic [CNT_WIDTH-1:0] mispredictCount
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0][1:0] tbl;
  logic [ENTRIES-1:0][1:0] tblNext;
  logic [INDEX_BITS-1:0]   idxF1, idxF2, idxE1, idxE2;
  logic                    upd1, upd2;

  // PC bits outside the index only exist to keep lint quiet about them.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcF1[PC_WIDTH-1:INDEX_BITS+2], pcF1[1:0],
                          pcF2[PC_WIDTH-1:INDEX_BITS+2], pcF2[1:0],
                          pcE1[PC_WIDTH-1:INDEX_BITS+2], pcE1[1:0],
                          pcE2[PC_WIDTH-1:INDEX_BITS+2], pcE2[1:0]};

  function automatic logic [1:0] satStep(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign idxF1 = pcF1[INDEX_BITS+1:2];
  assign idxF2 = pcF2[INDEX_BITS+1:2];
  assign idxE1 = pcE1[INDEX_BITS+1:2];
  assign idxE2 = pcE2[INDEX_BITS+1:2];

  // Slot 2 is wrong-path when slot 1 mispredicts, so it must not train.
  assign upd1 = enE & branchE1;
  assign upd2 = enE & branchE2 & ~CPCSignal1;

  // Fetch read straight from registered state; no bypass of same-edge writes.
  assign predictionF1 = tbl[idxF1][1];
  assign predictionF2 = tbl[idxF2][1];

  // Per-entry next value: slot-2 step is chained onto the slot-1 result so a
  // shared index sees both updates in order within one edge.
  for (genvar i = 0; i < ENTRIES; i++) begin : gEntry
    logic [1:0] afterS1;
    assign afterS1    = (upd1 && idxE1 == INDEX_BITS'(i)) ? satStep(tbl[i], takenBranch1) : tbl[i];
    assign tblNext[i] = (upd2 && idxE2 == INDEX_BITS'(i)) ? satStep(afterS1, takenBranch2) : afterS1;
  end

  // Table register: reset to weakly not-taken, otherwise take trained values.
  always_ff @(posedge clk) begin
    if (!rst) tbl <= {ENTRIES{2'b01}};
    else      tbl <= tblNext;
  end

  // Statistics: wrap modulo 2^CNT_WIDTH, 0..2 increments per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      branchCount     <= '0;
      mispredictCount <= '0;
    end else begin
      branchCount     <= branchCount + CNT_WIDTH'(upd1) + CNT_WIDTH'(upd2);
      mispredictCount <= mispredictCount + CNT_WIDTH'(upd1 & CPCSignal1)
                                         + CNT_WIDTH'(upd2 & CPCSignal2);
    end
  end
endmodule

// File: tb/tb_dual_branch_predictor.sv
// Directed bench for dual_branch_predictor with hand-computed expectations.
module tb_dual_branch_predictor;
  logic        clk = 0;
  logic        rst;
  logic [31:0] pcF1, pcF2, pcE1, pcE2;
  logic        predictionF1, predictionF2;
  logic        enE, branchE1, branchE2, takenBranch1, takenBranch2;
  logic        CPCSignal1, CPCSignal2;
  logic [31:0] branchCount, mispredictCount;
  int          nChk = 0, nPass = 0;

  dual_branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pcF1(pcF1), .pcF2(pcF2),
    .predictionF1(predictionF1), .predictionF2(predictionF2),
    .enE(enE), .pcE1(pcE1), .pcE2(pcE2), .branchE1(branchE1), .branchE2(branchE2),
    .takenBranch1(takenBranch1), .takenBranch2(takenBranch2),
    .CPCSignal1(CPCSignal1), .CPCSignal2(CPCSignal2),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    enE = 0; branchE1 = 0; branchE2 = 0; takenBranch1 = 0; takenBranch2 = 0;
    CPCSignal1 = 0; CPCSignal2 = 0;
  endtask

  // Slot-1-only training cycle.
  task automatic train1(input logic [31:0] pc, input logic t, input logic cpc);
    idle(); enE = 1; branchE1 = 1; pcE1 = pc; takenBranch1 = t; CPCSignal1 = cpc;
    step(); idle();
  endtask

  task automatic predAt(input string tag, input logic [31:0] pc, input logic exp);
    pcF1 = pc; #1; chk(tag, {31'b0, predictionF1}, {31'b0, exp});
  endtask

  initial begin
    idle(); pcE1 = 0; pcE2 = 0; pcF1 = 32'h40; pcF2 = 32'h44;
    rst = 0; step(); rst = 1; #1;
    chk("rstPredF1", {31'b0, predictionF1}, 0);
    chk("rstPredF2", {31'b0, predictionF2}, 0);
    chk("rstBranchCnt", branchCount, 0);
    chk("rstMispCnt", mispredictCount, 0);

    // Slot-1 taken mispredict at 0x40: 01 -> 10.
    train1(32'h40, 1, 1);
    pcF1 = 32'h40; pcF2 = 32'h44; #1;
    chk("s1PredF1", {31'b0, predictionF1}, 1);
    chk("s1PredF2", {31'b0, predictionF2}, 0);
    chk("s1BranchCnt", branchCount, 1);
    chk("s1MispCnt", mispredictCount, 1);

    // Saturation at 0x80.
    repeat (4) train1(32'h80, 1, 0);
    pcF2 = 32'h80; #1;
    chk("satTakenF2", {31'b0, predictionF2}, 1);
    train1(32'h80, 0, 0);                          // 11 -> 10
    predAt("sat11to10", 32'h80, 1);
    train1(32'h80, 0, 0); train1(32'h80, 0, 0);    // -> 00
    predAt("satTo00", 32'h80, 0);
    train1(32'h80, 0, 0);                          // holds 00
    train1(32'h80, 1, 0);                          // 00 -> 01
    predAt("satHeld00", 32'h80, 0);
    train1(32'h80, 1, 0);                          // 01 -> 10
    predAt("sat01to10", 32'h80, 1);
    chk("satBranchCnt", branchCount, 11);
    chk("satMispCnt", mispredictCount, 1);

    // Wrong-path squash: slot 1 mispredicts, slot 2 at 0xC0 must not train.
    idle(); enE = 1; branchE1 = 1; pcE1 = 32'h20; takenBranch1 = 0; CPCSignal1 = 1;
    branchE2 = 1; pcE2 = 32'hC0; takenBranch2 = 1; CPCSignal2 = 0;
    step(); idle();
    predAt("squashC0", 32'hC0, 0);
    chk("squashBranchCnt", branchCount, 12);
    chk("squashMispCnt", mispredictCount, 2);

    // Same-index dual update: 0x100 and 0x200 alias to entry 0; 01 -> 11.
    idle(); enE = 1; branchE1 = 1; pcE1 = 32'h100; takenBranch1 = 1;
    branchE2 = 1; pcE2 = 32'h200; takenBranch2 = 1;
    step(); idle();
    predAt("dualPred", 32'h100, 1);
    chk("dualBranchCnt", branchCount, 14);
    train1(32'h100, 0, 0);                         // 11 -> 10 (still taken)
    predAt("dualWas11", 32'h200, 1);
    train1(32'h100, 1, 0);                         // 10 -> 11
    // 11, slot1 not-taken then slot2 taken (slot 2 mispredict) -> 11.
    idle(); enE = 1; branchE1 = 1; pcE1 = 32'h100; takenBranch1 = 0;
    branchE2 = 1; pcE2 = 32'h200; takenBranch2 = 1; CPCSignal2 = 1;
    step(); idle();
    train1(32'h100, 0, 0);                         // 11 -> 10
    predAt("dualNtT11", 32'h100, 1);
    chk("dualBranchCnt2", branchCount, 19);
    chk("dualMispCnt", mispredictCount, 3);

    // enE=0: nothing trains, nothing counts.
    idle(); branchE1 = 1; pcE1 = 32'h44; takenBranch1 = 1; CPCSignal1 = 1;
    step(); idle();
    predAt("enE0Pred", 32'h44, 0);
    chk("enE0BranchCnt", branchCount, 19);
    chk("enE0MispCnt", mispredictCount, 3);

    // Mid-stream reset discards the pending training at 0x44.
    idle(); enE = 1; branchE1 = 1; pcE1 = 32'h44; takenBranch1 = 1; CPCSignal1 = 1;
    rst = 0; step(); rst = 1; idle();
    predAt("rstMid40", 32'h40, 0);
    predAt("rstMid44", 32'h44, 0);
    predAt("rstMid100", 32'h100, 0);
    chk("rstMidBranchCnt", branchCount, 0);
    chk("rstMidMispCnt", mispredictCount, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
